aes_io_bridge: RTL

- Host-side counterpart of the AES controller handshake.
- Takes the 128-bit key and message as four 32-bit host writes each and presents them as stable 128-bit buses.
- Releases the controller from reset, raises io_ready and waits for aes_ready, with a cycle timeout.
- Captures msg_de into host-readable result registers and reports status/irq.
- Sits between the processor register bus and the AES controller.

---
 rtl/aes_io_pkg.sv | 37 +++
 rtl/aes_io_regfile128.sv | 31 +++
 rtl/aes_io_bridge.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/aes_io_pkg.sv
// Shared types and constants for the host-side AES I/O bridge.
// Register map, FSM states and STATUS/CTRL bit positions live here.
package aes_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] ADDR_KEY0   = 4'd0;
  localparam logic [3:0] ADDR_MSG0   = 4'd4;
  localparam logic [3:0] ADDR_RES0   = 4'd8;
  localparam logic [3:0] ADDR_CTRL   = 4'd12;
  localparam logic [3:0] ADDR_STATUS = 4'd13;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_WR_ERR  = 3;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;

  // Word 0 is the most significant 32 bits of the 128-bit value.
  function automatic logic [31:0] word_of(input logic [127:0] d, input logic [1:0] sel);
    logic [31:0] w;
    case (sel)
      2'd0:    w = d[127:96];
      2'd1:    w = d[95:64];
      2'd2:    w = d[63:32];
      default: w = d[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_io_regfile128.sv
// Four 32-bit words viewed as one 128-bit bus; word 0 maps to bits [127:96].
// A parallel load takes priority over a single-word write.
module aes_io_regfile128 (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         we_i,
  input  logic [1:0]   wsel_i,
  input  logic [31:0]  wdata_i,
  input  logic         load_i,
  input  logic [127:0] load_data_i,
  output logic [127:0] data_o
);

  logic [127:0] data_q;
  logic [6:0]   base;

  assign base = {~wsel_i, 5'b00000};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_data_i;
    end else if (we_i) begin
      data_q[base +: 32] <= wdata_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/aes_io_bridge.sv
// Host register front-end for the AES controller: stages key/message, runs
// one controller job with a cycle timeout and exposes the result and status.
module aes_io_bridge #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         host_cs,
  input  logic         host_we,
  input  logic         host_re,
  input  logic [3:0]   host_addr,
  input  logic [31:0]  host_wdata,
  output logic [31:0]  host_rdata,
  output logic         irq,
  output logic [127:0] key_out,
  output logic [127:0] msg_out,
  output logic         aes_rst_n,
  output logic         io_ready,
  input  logic         aes_ready,
  input  logic [127:0] msg_de
);
  import aes_io_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, timeout_q, wr_err_q;
  logic [31:0]      host_rdata_q, rdata_d;
  logic [127:0]     result;
  logic [31:0]      status_w;

  logic             wr, rd, start, clear, busy;
  logic             key_we, msg_we, busy_wr, cnt_hit, res_load;
  logic [127:0]     res_data;

  assign wr      = host_cs & host_we;
  assign rd      = host_cs & host_re;
  assign start   = wr && (host_addr == ADDR_CTRL) && host_wdata[CTRL_START];
  assign clear   = wr && (host_addr == ADDR_CTRL) && host_wdata[CTRL_CLEAR];
  // KEY/MSG are frozen while the controller is out of reset.
  assign key_we  = wr && (host_addr[3:2] == ADDR_KEY0[3:2]) && (state_q != ST_RUN);
  assign msg_we  = wr && (host_addr[3:2] == ADDR_MSG0[3:2]) && (state_q != ST_RUN);
  assign busy_wr = wr && !host_addr[3] && (state_q == ST_RUN);
  assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  // aes_ready wins over a simultaneous timeout.
  assign res_load = (state_q == ST_RUN) && (aes_ready || cnt_hit);
  assign res_data = aes_ready ? msg_de : '0;

  aes_io_regfile128 u_key (
    .clk_i(clk), .rst_ni(reset_n), .we_i(key_we), .wsel_i(host_addr[1:0]),
    .wdata_i(host_wdata), .load_i(1'b0), .load_data_i('0), .data_o(key_out)
  );

  aes_io_regfile128 u_msg (
    .clk_i(clk), .rst_ni(reset_n), .we_i(msg_we), .wsel_i(host_addr[1:0]),
    .wdata_i(host_wdata), .load_i(1'b0), .load_data_i('0), .data_o(msg_out)
  );

  aes_io_regfile128 u_res (
    .clk_i(clk), .rst_ni(reset_n), .we_i(1'b0), .wsel_i(2'b00),
    .wdata_i(host_wdata), .load_i(res_load), .load_data_i(res_data), .data_o(result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == ST_RUN) ? cnt_q + CNT_W'(1) : '0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (aes_ready || cnt_hit) state_d = ST_DONE;
      ST_DONE: begin
        if (start)      state_d = ST_RUN;
        else if (clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode only the state register, so they never glitch.
  always_comb begin
    busy      = (state_q == ST_RUN);
    aes_rst_n = busy;
    io_ready  = busy;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else if (state_q != ST_RUN && start) begin
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      wr_err_q  <= 1'b0;
    end else if (state_q == ST_RUN) begin
      if (busy_wr) wr_err_q <= 1'b1;
      if (aes_ready) begin
        done_q <= 1'b1;
      end else if (cnt_hit) begin
        done_q    <= 1'b1;
        timeout_q <= 1'b1;
      end
    end else if (state_q == ST_DONE && clear) begin
      done_q <= 1'b0;
    end
  end

  always_comb begin
    status_w               = '0;
    status_w[STAT_BUSY]    = busy;
    status_w[STAT_DONE]    = done_q;
    status_w[STAT_TIMEOUT] = timeout_q;
    status_w[STAT_WR_ERR]  = wr_err_q;
  end

  // Read data is built from pre-write register values.
  always_comb begin
    rdata_d = host_rdata_q;
    if (rd) begin
      case (host_addr[3:2])
        ADDR_KEY0[3:2]: rdata_d = word_of(key_out, host_addr[1:0]);
        ADDR_MSG0[3:2]: rdata_d = word_of(msg_out, host_addr[1:0]);
        ADDR_RES0[3:2]: rdata_d = word_of(result, host_addr[1:0]);
        default:        rdata_d = (host_addr == ADDR_STATUS) ? status_w : 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) host_rdata_q <= '0;
    else          host_rdata_q <= rdata_d;
  end

  assign host_rdata = host_rdata_q;
  assign irq        = done_q;

endmodule
